// File: rtl/spike_log_pipe_out.sv
// Host-bound logging buffer: each sample tick queues a 32-bit observable as
// two 16-bit words (low, then high) for a block-throttled pipe-out endpoint.
module spike_log_pipe_out #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [31:0]       sample_data,
    input  logic              pipe_read,
    output logic [15:0]       pipe_dataout,
    output logic              pipe_ready,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       overflow_cnt,
    output logic              overflow_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, WR_HI} state_t;

    state_t              state, state_nx;
    logic [15:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nx;
    logic [15:0]         hi_q;
    logic [15:0]         wr_data;
    logic                wr_en, drop, rd_ok, has_room;
    logic [ADDR_W:0]     level_left;

    // Room is judged on the start-of-cycle level; a same-cycle read gives no credit.
    assign has_room   = int'(level) <= DEPTH - 2;
    assign rd_ok      = pipe_read && (level != '0);
    assign rd_ptr_nx  = rd_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
    assign level_left = level - {{ADDR_W{1'b0}}, rd_ok};

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_data  = hi_q;
        drop     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick) begin
                    if (has_room) begin
                        wr_en    = 1'b1;
                        wr_data  = sample_data[15:0];
                        state_nx = WR_HI;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WR_HI: begin
                wr_en    = 1'b1;
                drop     = sample_tick;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage and the held high half are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_ptr] <= wr_data;
        if (state == IDLE && wr_en)
            hi_q <= sample_data[31:16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            overflow_cnt  <= 16'h0000;
            overflow_flag <= 1'b0;
            pipe_dataout  <= 16'h0000;
            pipe_ready    <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_ptr <= rd_ptr_nx;
            if (wr_en)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            case ({wr_en, rd_ok})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow_flag <= 1'b1;
                if (overflow_cnt != 16'hFFFF)
                    overflow_cnt <= overflow_cnt + 16'd1;
            end
            // Only words already in memory before this edge are presented, so a
            // fresh low word appears one cycle after it lands.
            pipe_dataout <= (level_left == '0) ? 16'h0000 : mem[rd_ptr_nx];
            pipe_ready   <= int'(level) >= BLOCK_WORDS;
        end
    end

endmodule

// File: tb/tb_spike_log_pipe_out.sv
// Directed bench for spike_log_pipe_out with ADDR_W=4, BLOCK_WORDS=4.
module tb_spike_log_pipe_out;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] sample_data = 32'h0;
    logic        pipe_read = 1'b0;
    logic [15:0] pipe_dataout;
    logic        pipe_ready;
    logic [4:0]  level;
    logic [15:0] overflow_cnt;
    logic        overflow_flag;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] expq[$];

    spike_log_pipe_out #(.ADDR_W(4), .BLOCK_WORDS(4)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .sample_data(sample_data),
        .pipe_read(pipe_read), .pipe_dataout(pipe_dataout), .pipe_ready(pipe_ready),
        .level(level), .overflow_cnt(overflow_cnt), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic tick(input logic [31:0] d);
        sample_tick = 1'b1;
        sample_data = d;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [15:0] exp);
        chk(tag, pipe_dataout, exp);
        pipe_read = 1'b1;
        step();
        pipe_read = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_data"},  pipe_dataout, 0);
        chk({tag, "_ready"}, pipe_ready, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_empty("rst");
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_flag", overflow_flag, 0);

        // Basic order and readiness lag
        tick(32'h1111_AAAA);
        chk("t1_lvl1", level, 1);
        chk("t1_data_lat", pipe_dataout, 16'h0000);
        step();
        chk("t1_lvl2", level, 2);
        chk("t1_data_lo", pipe_dataout, 16'hAAAA);
        repeat (3) step();
        tick(32'h2222_BBBB);
        chk("t1_lvl3", level, 3);
        step();
        chk("t1_lvl4", level, 4);
        chk("t1_rdy_lag", pipe_ready, 0);
        step();
        chk("t1_rdy", pipe_ready, 1);
        read_word("t1_r0", 16'hAAAA);
        read_word("t1_r1", 16'h1111);
        read_word("t1_r2", 16'hBBBB);
        read_word("t1_r3", 16'h2222);
        chk_empty("t1_end");

        // Overflow: ninth sample is dropped whole
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick({16'h1000 + 16'(i), 16'h0A00 + 16'(i)});
            step();
        end
        chk("t2_full", level, 16);
        chk("t2_ovf0", overflow_cnt, 0);
        tick(32'hDEAD_BEEF);
        chk("t2_ovf1", overflow_cnt, 1);
        chk("t2_flag", overflow_flag, 1);
        chk("t2_lvl", level, 16);
        for (int i = 0; i < 8; i++) begin
            read_word("t2_lo", 16'h0A00 + 16'(i));
            read_word("t2_hi", 16'h1000 + 16'(i));
        end
        chk_empty("t2_end");
        chk("t2_flag_sticky", overflow_flag, 1);

        // Tick on consecutive cycles: the second lands in WR_HI
        do_reset();
        sample_tick = 1'b1;
        sample_data = 32'h3333_CCCC;
        step();
        sample_data = 32'h4444_DDDD;
        step();
        sample_tick = 1'b0;
        chk("t3_lvl", level, 2);
        chk("t3_ovf", overflow_cnt, 1);
        chk("t3_flag", overflow_flag, 1);
        step();
        read_word("t3_lo", 16'hCCCC);
        read_word("t3_hi", 16'h3333);
        chk_empty("t3_end");

        // Simultaneous write and read at level 3
        do_reset();
        tick(32'h5151_A1A1);
        step();
        tick(32'h5252_A2A2);
        step();
        read_word("t4_r0", 16'hA1A1);
        chk("t4_lvl3", level, 3);
        chk("t4_data", pipe_dataout, 16'h5151);
        sample_tick = 1'b1;
        sample_data = 32'h5353_A3A3;
        pipe_read   = 1'b1;
        step();
        sample_tick = 1'b0;
        pipe_read   = 1'b0;
        chk("t4_lvlT", level, 3);
        chk("t4_next", pipe_dataout, 16'hA2A2);
        step();
        chk("t4_lvlT1", level, 4);
        read_word("t4_r2", 16'hA2A2);
        read_word("t4_r3", 16'h5252);
        read_word("t4_r4", 16'hA3A3);
        read_word("t4_r5", 16'h5353);
        chk_empty("t4_end");

        // Streaming across pointer wrap, then reads on an empty buffer
        do_reset();
        expq.delete();
        for (int i = 0; i < 2; i++) begin
            tick({16'hB000 + 16'(i), 16'hC000 + 16'(i)});
            expq.push_back(16'hC000 + 16'(i));
            expq.push_back(16'hB000 + 16'(i));
            step();
        end
        for (int i = 2; i < 40; i++) begin
            chk("t5_a", pipe_dataout, expq.pop_front());
            sample_tick = 1'b1;
            sample_data = {16'hB000 + 16'(i), 16'hC000 + 16'(i)};
            expq.push_back(16'hC000 + 16'(i));
            expq.push_back(16'hB000 + 16'(i));
            pipe_read = 1'b1;
            step();
            sample_tick = 1'b0;
            chk("t5_b", pipe_dataout, expq.pop_front());
            step();
            pipe_read = 1'b0;
        end
        chk("t5_lvl", level, 4);
        while (expq.size() > 0)
            read_word("t5_drain", expq.pop_front());
        chk_empty("t5_end");
        pipe_read = 1'b1;
        repeat (3) begin
            step();
            chk("t5_under_lvl", level, 0);
            chk("t5_under_data", pipe_dataout, 0);
        end
        pipe_read = 1'b0;
        chk("t5_ovf", overflow_cnt, 0);

        // Reset during the high-half write
        do_reset();
        tick(32'h7777_EEEE);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_empty("t6_rst");
        chk("t6_ovf", overflow_cnt, 0);
        chk("t6_flag", overflow_flag, 0);
        tick(32'h8888_9999);
        step();
        chk("t6_lvl", level, 2);
        chk("t6_ovf2", overflow_cnt, 0);
        step();
        read_word("t6_lo", 16'h9999);
        read_word("t6_hi", 16'h8888);
        chk_empty("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
